dcache_miss_ctrl: RTL and testbench

DCACHE_MISS_CTRL -- requirements
Module: dcache_miss_ctrl

---
 rtl/dcache_miss_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_miss_ctrl
// Direct-mapped, write-back, write-allocate data cache with a word-serial
// miss engine. Hits complete combinationally in IDLE; a miss stalls the core
// and moves whole lines to and from memory one word per mem_ack.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   CpuRst       synchronous active-high reset
//   rd_req       load request from the MEM stage
//   wr_req       store request from the MEM stage (wins over rd_req)
//   addr         byte address, bits[1:0] ignored
//   wr_data      store data
//   rd_data      load data, valid while rd_req=1 and DCacheMiss=0
//   DCacheMiss   stall request to the hazard unit
//   mem_rd_req   memory word read request (REFILL)
//   mem_wr_req   memory word write request (WRITEBACK)
//   mem_addr     word-aligned memory address
//   mem_wr_data  writeback word
//   mem_rd_data  refill word, valid with mem_ack
//   mem_ack      one-cycle pulse completing the current word transfer
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | serve hits; on a miss pick WRITEBACK (dirty victim) or REFILL
// WRITEBACK | stream the dirty victim line out, one word per mem_ack
// REFILL    | fetch the requested line, one word per mem_ack, then IDLE
// ---------------------------------------------------------------------------
module dcache_miss_ctrl #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int WORD_ADDR_LEN = 2,
    parameter int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - WORD_ADDR_LEN
) (
    input  logic        clk,
    input  logic        CpuRst,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        DCacheMiss,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_ack
);

    localparam int NLINES = 1 << LINE_ADDR_LEN;
    localparam int NWORDS = 1 << WORD_ADDR_LEN;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [WORD_ADDR_LEN-1:0] cnt_q, cnt_d;

    logic [NLINES-1:0]        valid_q;
    logic [NLINES-1:0]        dirty_q;
    logic [TAG_ADDR_LEN-1:0]  tag_q  [NLINES];
    logic [31:0]              data_q [NLINES][NWORDS];

    logic [LINE_ADDR_LEN-1:0] idx;
    logic [WORD_ADDR_LEN-1:0] off;
    logic [TAG_ADDR_LEN-1:0]  req_tag;
    logic                     req;
    logic                     hit;
    logic                     last_word;
    logic                     store_hit;
    logic                     unused_addr_bits;

    assign idx       = addr[WORD_ADDR_LEN+LINE_ADDR_LEN+1 : WORD_ADDR_LEN+2];
    assign off       = addr[WORD_ADDR_LEN+1 : 2];
    assign req_tag   = addr[31 -: TAG_ADDR_LEN];
    assign req       = rd_req | wr_req;
    assign hit       = (state_q == S_IDLE) && req && valid_q[idx] && (tag_q[idx] == req_tag);
    assign last_word = &cnt_q;
    // A combined rd_req/wr_req is a store.
    assign store_hit = hit && wr_req;
    assign unused_addr_bits = ^addr[1:0];

    assign rd_data = data_q[idx][off];

    // State register
    always_ff @(posedge clk) begin
        if (CpuRst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter is zero on entry to either transfer state
    // because it is held at zero in IDLE and forced to zero on the
    // WRITEBACK -> REFILL hand-over.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req && !hit) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_REFILL;
                end
            end
            S_WRITEBACK: begin
                if (mem_ack) begin
                    if (last_word) begin
                        state_d = S_REFILL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + WORD_ADDR_LEN'(1);
                    end
                end
            end
            S_REFILL: begin
                if (mem_ack) begin
                    if (last_word) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + WORD_ADDR_LEN'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        DCacheMiss  = 1'b0;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        case (state_q)
            S_IDLE: begin
                DCacheMiss = req && !hit;
            end
            S_WRITEBACK: begin
                DCacheMiss  = 1'b1;
                mem_wr_req  = 1'b1;
                mem_addr    = {tag_q[idx], idx, cnt_q, 2'b00};
                mem_wr_data = data_q[idx][cnt_q];
            end
            S_REFILL: begin
                DCacheMiss = 1'b1;
                mem_rd_req = 1'b1;
                mem_addr   = {req_tag, idx, cnt_q, 2'b00};
            end
            default: begin
                DCacheMiss = 1'b0;
            end
        endcase
        // The hazard unit must not see a stall while the core is in reset.
        if (CpuRst) begin
            DCacheMiss = 1'b0;
        end
    end

    // Line status bits: the only per-line state that reset clears.
    always_ff @(posedge clk) begin
        if (CpuRst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (state_q == S_REFILL && mem_ack && last_word) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data arrays keep their contents across reset; writes are only
    // suppressed while reset is asserted so an aborted refill leaves no trace
    // that could be mistaken for a valid line.
    always_ff @(posedge clk) begin
        if (!CpuRst) begin
            if (state_q == S_REFILL && mem_ack) begin
                data_q[idx][cnt_q] <= mem_rd_data;
                if (last_word) begin
                    tag_q[idx] <= req_tag;
                end
            end else if (store_hit) begin
                data_q[idx][off] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
module tb_dcache_miss_ctrl;

    logic        clk = 1'b0;
    logic        CpuRst;
    logic        rd_req, wr_req;
    logic [31:0] addr, wr_data;
    logic [31:0] rd_data;
    logic        DCacheMiss;
    logic        mem_rd_req, mem_wr_req;
    logic [31:0] mem_addr, mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_ack;

    always #5 clk = ~clk;

    dcache_miss_ctrl dut (
        .clk        (clk),
        .CpuRst     (CpuRst),
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .DCacheMiss (DCacheMiss),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data),
        .mem_ack    (mem_ack)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- backing memory and transfer log ----------------
    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
    } txn_t;

    txn_t        log_q[$];
    logic [31:0] bmem [logic [31:0]];
    logic [31:0] arch [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return 32'h1000 + (a >> 2) - 32'h10;   // 0x40+4k -> 0x1000+k
    endfunction

    function automatic logic [31:0] bmem_get(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] arch_get(input logic [31:0] a);
        if (arch.exists(a)) return arch[a];
        return init_word(a);
    endfunction

    bit resp_en    = 1'b1;
    bit inject_ack = 1'b0;
    bit rand_lat   = 1'b0;
    int lat        = 3;
    int wcnt       = 0;

    initial begin
        mem_ack     = 1'b0;
        mem_rd_data = '0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (inject_ack) begin
                inject_ack  = 1'b0;
                mem_ack     = 1'b1;
                mem_rd_data = 32'hBAD0BAD0;
            end else if (resp_en && (mem_rd_req || mem_wr_req)) begin
                wcnt++;
                if (wcnt >= lat) begin
                    mem_ack = 1'b1;
                    if (mem_wr_req) begin
                        bmem[mem_addr] = mem_wr_data;
                        log_q.push_back('{1'b1, mem_addr, mem_wr_data});
                    end else begin
                        mem_rd_data = bmem_get(mem_addr);
                        log_q.push_back('{1'b0, mem_addr, mem_rd_data});
                    end
                    lat = rand_lat ? int'($urandom_range(1, 4)) : 3;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // ---------------- always-on protocol checks ----------------
    bit mon_en = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                check("mem_req_exclusive", 32'(mem_rd_req & mem_wr_req), 32'd0);
                if (CpuRst) check("miss_during_reset", 32'(DCacheMiss), 32'd0);
                else if (!DCacheMiss) check("idle_mem_req", {30'd0, mem_rd_req, mem_wr_req}, 32'd0);
            end
        end
    end

    // ---------------- reference model ----------------
    // Architectural memory view plus which line base each index holds.
    bit          m_valid [8];
    bit          m_dirty [8];
    logic [31:0] m_base  [8];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        bit          miss;
        bit          wb;
        logic [31:0] wb_base;
        bit          chk_rd;
        logic [31:0] rdv;
    } vec_t;

    function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                                input bit miss, input bit wb, input logic [31:0] wb_base,
                                input bit chk_rd, input logic [31:0] rdv);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.miss = miss; v.wb = wb;
        v.wb_base = wb_base; v.chk_rd = chk_rd; v.rdv = rdv;
        return v;
    endfunction

    function automatic vec_t predict(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        int          i    = int'(a[6:4]);
        logic [31:0] base = a & ~32'hF;
        bit          miss = !(m_valid[i] && m_base[i] == base);
        return mk(rd, wr, a, d, miss, miss && m_valid[i] && m_dirty[i], m_base[i],
                  rd && !wr, arch_get(a));
    endfunction

    function automatic void model_commit(input vec_t v);
        int i = int'(v.a[6:4]);
        if (v.miss) begin
            m_valid[i] = 1'b1;
            m_base[i]  = v.a & ~32'hF;
            m_dirty[i] = 1'b0;
        end
        if (v.wr) begin
            arch[v.a]  = v.d;
            m_dirty[i] = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i] && m_dirty[i])
                for (int k = 0; k < 4; k++) arch[m_base[i] + 32'(4*k)] = bmem_get(m_base[i] + 32'(4*k));
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endfunction

    // ---------------- one request, checked end to end ----------------
    task automatic run_vec(input vec_t v, input string nm);
        logic [31:0] rdat;
        bit          fm;
        int          n;
        int          exp_n;
        rdat = '0;
        @(negedge clk);
        rd_req = v.rd; wr_req = v.wr; addr = v.a; wr_data = v.d;
        log_q.delete();
        #1;
        fm = DCacheMiss;
        n  = 0;
        while (DCacheMiss !== 1'b0 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({nm, "_first_miss"}, 32'(fm), 32'(v.miss));
        check({nm, "_miss_done"}, 32'(DCacheMiss), 32'd0);
        rdat = rd_data;
        @(posedge clk);
        #1;
        rd_req = 1'b0; wr_req = 1'b0;
        exp_n = (v.wb ? 4 : 0) + (v.miss ? 4 : 0);
        check({nm, "_ntxn"}, 32'(log_q.size()), 32'(exp_n));
        for (int k = 0; k < log_q.size() && k < exp_n; k++) begin
            bit          ew;
            logic [31:0] ea;
            if (v.wb && k < 4) begin
                ew = 1'b1; ea = v.wb_base + 32'(4*k);
            end else begin
                ew = 1'b0; ea = (v.a & ~32'hF) + 32'(4*(k % 4));
            end
            check({nm, "_txn_addr"}, log_q[k].a, ea);
            check({nm, "_txn_dir"}, 32'(log_q[k].wr), 32'(ew));
        end
        if (v.wb)
            for (int k = 0; k < 4; k++)
                check({nm, "_wb_data"}, bmem_get(v.wb_base + 32'(4*k)), arch_get(v.wb_base + 32'(4*k)));
        if (v.chk_rd) check({nm, "_rd_data"}, rdat, v.rdv);
        model_commit(v);
    endtask

    vec_t tbl [11];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   n;
        for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_base[i] = '0; end

        //           rd wr addr          data          miss wb wb_base     chk rd value
        tbl[0]  = mk(1, 0, 32'h048, 32'h0,        1,  0, 32'h0,   1, 32'h0000_1002);
        tbl[1]  = mk(1, 0, 32'h04C, 32'h0,        0,  0, 32'h0,   1, 32'h0000_1003);
        tbl[2]  = mk(0, 1, 32'h044, 32'hDEADBEEF, 0,  0, 32'h0,   0, 32'h0);
        tbl[3]  = mk(1, 0, 32'h140, 32'h0,        1,  1, 32'h040, 1, 32'h0000_1040);
        tbl[4]  = mk(0, 1, 32'h204, 32'hCAFE0001, 1,  0, 32'h0,   0, 32'h0);
        tbl[5]  = mk(1, 0, 32'h204, 32'h0,        0,  0, 32'h0,   1, 32'hCAFE0001);
        tbl[6]  = mk(1, 1, 32'h208, 32'h5555AAAA, 0,  0, 32'h0,   0, 32'h0);
        tbl[7]  = mk(1, 0, 32'h208, 32'h0,        0,  0, 32'h0,   1, 32'h5555AAAA);
        tbl[8]  = mk(1, 0, 32'h044, 32'h0,        1,  0, 32'h0,   1, 32'hDEADBEEF);
        tbl[9]  = mk(1, 0, 32'h600, 32'h0,        1,  1, 32'h200, 1, 32'h0000_1170);
        tbl[10] = mk(1, 0, 32'h208, 32'h0,        1,  0, 32'h0,   1, 32'h5555AAAA);

        // Reset with a request pending: no stall and no memory traffic.
        CpuRst = 1'b1; rd_req = 1'b1; wr_req = 1'b0; addr = 32'h48; wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_miss", 32'(DCacheMiss), 32'd0);
        check("reset_mem_req", {30'd0, mem_rd_req, mem_wr_req}, 32'd0);
        rd_req = 1'b0;
        CpuRst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
        check("wb_word_0x44", bmem_get(32'h44), 32'hDEADBEEF);

        // Store request withdrawn mid-miss: refill finishes, store is dropped.
        v = predict(1'b1, 1'b0, 32'h700, 32'h0);
        @(negedge clk);
        wr_req = 1'b1; addr = 32'h700; wr_data = 32'h12345678; log_q.delete();
        n = 0;
        while (log_q.size() < 1 && n < 200) begin @(negedge clk); #1; n++; end
        check("drop_first_ack", 32'(log_q.size() >= 1), 32'd1);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        n = 0;
        while (DCacheMiss !== 1'b0 && n < 200) begin @(negedge clk); #1; n++; end
        check("drop_completes", 32'(DCacheMiss), 32'd0);
        check("drop_reads", 32'(log_q.size()), 32'd4);
        model_commit(v);
        run_vec(mk(1, 0, 32'h700, 32'h0, 0, 0, 32'h0, 1, 32'h0000_11B0), "drop_readback");

        // Reset after the second refill word; a late ack must be ignored.
        @(negedge clk);
        rd_req = 1'b1; addr = 32'h3A0; log_q.delete();
        n = 0;
        while (log_q.size() < 2 && n < 200) begin @(negedge clk); #1; n++; end
        check("rst_two_acks", 32'(log_q.size()), 32'd2);
        @(posedge clk);
        #1;
        CpuRst = 1'b1; resp_en = 1'b0; rd_req = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mem_rd_req", 32'(mem_rd_req), 32'd0);
        check("rst_miss", 32'(DCacheMiss), 32'd0);
        CpuRst = 1'b0;
        inject_ack = 1'b1;
        @(posedge clk);
        #1;
        check("stray_ack_mem_req", {30'd0, mem_rd_req, mem_wr_req}, 32'd0);
        resp_en = 1'b1;
        model_reset();
        run_vec(mk(1, 0, 32'h3A0, 32'h0, 1, 0, 32'h0, 1, 32'h0000_10D8), "rst_refetch");

        // Random traffic against the reference model.
        rand_lat = 1'b1;
        for (int i = 0; i < 250; i++) begin
            int          op;
            logic [31:0] a;
            op = int'($urandom_range(0, 3));
            a  = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4)
               | (32'($urandom_range(0, 3)) << 2);
            v  = predict(op != 2, op >= 2, a, $urandom);
            run_vec(v, "rnd");
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
